// File: rtl/punc_control_pkg.sv
// Shared opcode, state and datapath select encodings for the PUnC controller and datapath.
package punc_control_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC1, ST_EXEC2, ST_EXEC3, ST_HALT
    } state_e;

    localparam logic [1:0] ADDR_PC    = 2'b00;
    localparam logic [1:0] ADDR_ALU   = 2'b01;
    localparam logic [1:0] ADDR_STORE = 2'b10;

    localparam logic [1:0] RF_W_PC  = 2'b00;
    localparam logic [1:0] RF_W_MEM = 2'b01;
    localparam logic [1:0] RF_W_ALU = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_AND    = 2'b01;
    localparam logic [1:0] ALU_PASS_A = 2'b10;
    localparam logic [1:0] ALU_NOT    = 2'b11;

    localparam logic A_PC   = 1'b0;
    localparam logic A_RF0  = 1'b1;
    localparam logic B_RF1  = 1'b0;
    localparam logic B_SEXT = 1'b1;

    localparam logic NZP_ALU = 1'b0;
    localparam logic NZP_RF0 = 1'b1;

    // PC source: adder (PC + offset) or ALU; the adder picks off11 (0) or off9 (1).
    localparam logic PC_DATA_ADD  = 1'b0;
    localparam logic PC_DATA_ALU  = 1'b1;
    localparam logic PC_ADD_OFF11 = 1'b0;
    localparam logic PC_ADD_OFF9  = 1'b1;

    function automatic logic br_taken(input logic [2:0] mask, input logic n, input logic z,
                                      input logic p);
        return (mask[2] & n) | (mask[1] & z) | (mask[0] & p);
    endfunction

endpackage

// File: rtl/punc_control_if.sv
// Control/status bundle between the PUnC controller (master) and its datapath (slave).
interface punc_control_if;
    logic [15:0] ir;
    logic        n_flag, z_flag, p_flag;
    logic        PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld;
    logic [1:0]  addr_MEM_sel;
    logic        w_en_MEM;
    logic [1:0]  w_RF_sel;
    logic [2:0]  r_addr_0_RF, r_addr_1_RF, w_addr_RF;
    logic        w_en_RF;
    logic [15:0] sext_data;
    logic        A_sel, B_sel;
    logic [1:0]  ALU_sel;
    logic        NZP_sel, N_ld, Z_ld, P_ld;
    logic        store_ld;
    logic        halted;

    modport master (
        input  ir, n_flag, z_flag, p_flag,
        output PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld, addr_MEM_sel, w_en_MEM,
               w_RF_sel, r_addr_0_RF, r_addr_1_RF, w_addr_RF, w_en_RF, sext_data, A_sel, B_sel,
               ALU_sel, NZP_sel, N_ld, Z_ld, P_ld, store_ld, halted
    );

    modport slave (
        output ir, n_flag, z_flag, p_flag,
        input  PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld, addr_MEM_sel, w_en_MEM,
               w_RF_sel, r_addr_0_RF, r_addr_1_RF, w_addr_RF, w_en_RF, sext_data, A_sel, B_sel,
               ALU_sel, NZP_sel, N_ld, Z_ld, P_ld, store_ld, halted
    );
endinterface

// File: rtl/punc_control_imm_gen.sv
// Sign-extends the immediate field the current opcode uses (imm5/off6/off9/off11) to 16 bits.
module punc_imm_gen
    import punc_control_pkg::*;
(
    input  opcode_e     opcode_i,
    input  logic [10:0] field_i,
    output logic [15:0] sext_o
);

    always_comb begin
        sext_o = '0;
        case (opcode_i)
            OP_ADD, OP_AND: sext_o = {{11{field_i[4]}}, field_i[4:0]};
            OP_LDR, OP_STR: sext_o = {{10{field_i[5]}}, field_i[5:0]};
            OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA:
                            sext_o = {{7{field_i[8]}}, field_i[8:0]};
            OP_JSR:         sext_o = {{5{field_i[10]}}, field_i};
            default:        sext_o = '0;
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// Multi-cycle LC3 control FSM: fetch, decode and sequence each instruction over the PUnC datapath.
module punc_control
    import punc_control_pkg::*;
#(
    parameter logic [2:0] LINK_REG      = 3'd7,
    parameter bit         ILLEGAL_HALTS = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    punc_control_if.master bus
);

    state_e     state_q, state_d;
    opcode_e    op;
    logic [2:0] dr, sr1;

    assign op  = opcode_e'(bus.ir[15:12]);
    assign dr  = bus.ir[11:9];
    assign sr1 = bus.ir[8:6];

    punc_imm_gen u_imm_gen (
        .opcode_i (op),
        .field_i  (bus.ir[10:0]),
        .sext_o   (bus.sext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.PC_data_sel  = PC_DATA_ADD;
        bus.PC_add_sel   = PC_ADD_OFF11;
        bus.PC_ld        = 1'b0;
        bus.PC_clr       = 1'b0;
        bus.PC_inc       = 1'b0;
        bus.IR_ld        = 1'b0;
        bus.addr_MEM_sel = ADDR_PC;
        bus.w_en_MEM     = 1'b0;
        bus.w_RF_sel     = RF_W_PC;
        bus.r_addr_0_RF  = 3'd0;
        bus.r_addr_1_RF  = 3'd0;
        bus.w_addr_RF    = 3'd0;
        bus.w_en_RF      = 1'b0;
        bus.A_sel        = A_PC;
        bus.B_sel        = B_RF1;
        bus.ALU_sel      = ALU_ADD;
        bus.NZP_sel      = NZP_ALU;
        bus.N_ld         = 1'b0;
        bus.Z_ld         = 1'b0;
        bus.P_ld         = 1'b0;
        bus.store_ld     = 1'b0;
        bus.halted       = 1'b0;

        case (state_q)
            ST_INIT: begin
                bus.PC_clr = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                bus.IR_ld = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                bus.PC_inc = 1'b1;
                state_d    = ST_EXEC1;
            end
            // PC already points at the next instruction here.
            ST_EXEC1: begin
                state_d = ST_FETCH;
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        bus.r_addr_0_RF = sr1;
                        bus.A_sel       = A_RF0;
                        if (op == OP_NOT) begin
                            bus.ALU_sel = ALU_NOT;
                        end else begin
                            bus.ALU_sel     = (op == OP_AND) ? ALU_AND : ALU_ADD;
                            bus.B_sel       = bus.ir[5] ? B_SEXT : B_RF1;
                            bus.r_addr_1_RF = bus.ir[2:0];
                        end
                        bus.w_RF_sel  = RF_W_ALU;
                        bus.w_addr_RF = dr;
                        bus.w_en_RF   = 1'b1;
                        bus.N_ld      = 1'b1;
                        bus.Z_ld      = 1'b1;
                        bus.P_ld      = 1'b1;
                    end
                    OP_BR: begin
                        bus.PC_add_sel = PC_ADD_OFF9;
                        bus.PC_ld      = br_taken(bus.ir[11:9], bus.n_flag, bus.z_flag, bus.p_flag);
                    end
                    OP_JMP: begin
                        bus.r_addr_0_RF = sr1;
                        bus.A_sel       = A_RF0;
                        bus.ALU_sel     = ALU_PASS_A;
                        bus.PC_data_sel = PC_DATA_ALU;
                        bus.PC_ld       = 1'b1;
                    end
                    // Link write and PC load share the cycle; JSRR R7 reads the old R7.
                    OP_JSR: begin
                        bus.w_RF_sel  = RF_W_PC;
                        bus.w_addr_RF = LINK_REG;
                        bus.w_en_RF   = 1'b1;
                        bus.PC_ld     = 1'b1;
                        if (bus.ir[11]) begin
                            bus.PC_add_sel  = PC_ADD_OFF11;
                        end else begin
                            bus.r_addr_0_RF = sr1;
                            bus.A_sel       = A_RF0;
                            bus.ALU_sel     = ALU_PASS_A;
                            bus.PC_data_sel = PC_DATA_ALU;
                        end
                    end
                    OP_LD, OP_LDR, OP_ST, OP_STR, OP_LEA, OP_LDI, OP_STI: begin
                        bus.r_addr_0_RF  = sr1;
                        bus.A_sel        = (op == OP_LDR || op == OP_STR) ? A_RF0 : A_PC;
                        bus.B_sel        = B_SEXT;
                        bus.ALU_sel      = ALU_ADD;
                        bus.addr_MEM_sel = ADDR_ALU;
                        bus.w_addr_RF    = dr;
                        bus.r_addr_1_RF  = dr;
                        if (op == OP_LD || op == OP_LDR) begin
                            bus.w_RF_sel = RF_W_MEM;
                            bus.w_en_RF  = 1'b1;
                            state_d      = ST_EXEC3;
                        end else if (op == OP_LEA) begin
                            bus.w_RF_sel = RF_W_ALU;
                            bus.w_en_RF  = 1'b1;
                        end else if (op == OP_ST || op == OP_STR) begin
                            bus.w_en_MEM = 1'b1;
                        end else begin
                            bus.store_ld = 1'b1;
                            state_d      = ST_EXEC2;
                        end
                    end
                    OP_TRAP:        state_d = ST_HALT;
                    OP_RTI, OP_RES: state_d = ILLEGAL_HALTS ? ST_HALT : ST_FETCH;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_EXEC2: begin
                bus.addr_MEM_sel = ADDR_STORE;
                if (op == OP_LDI) begin
                    bus.w_RF_sel  = RF_W_MEM;
                    bus.w_addr_RF = dr;
                    bus.w_en_RF   = 1'b1;
                    state_d       = ST_EXEC3;
                end else begin
                    bus.r_addr_1_RF = dr;
                    bus.w_en_MEM    = 1'b1;
                    state_d         = ST_FETCH;
                end
            end
            ST_EXEC3: begin
                bus.r_addr_0_RF = dr;
                bus.NZP_sel     = NZP_RF0;
                bus.N_ld        = 1'b1;
                bus.Z_ld        = 1'b1;
                bus.P_ld        = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_HALT: begin
                bus.halted = 1'b1;
                state_d    = ST_HALT;
            end
            default: state_d = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Directed-vector bench for the PUnC control FSM with hand-computed expected control values.
module tb_punc_control;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    punc_control_if bus ();

    punc_control #(.LINK_REG(3'd7), .ILLEGAL_HALTS(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH: present the instruction, advance through DECODE into EXEC1.
    task automatic to_exec1(input logic [15:0] instr);
        bus.ir = instr;
        step();
        chk("decode_pc_inc", 16'(bus.PC_inc), 16'd1);
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.ir = 16'h0000;
        bus.n_flag = 1'b0;
        bus.z_flag = 1'b0;
        bus.p_flag = 1'b0;

        // reset and INIT
        step();
        chk("rst_pc_clr", 16'(bus.PC_clr), 16'd1);
        chk("rst_ir_ld", 16'(bus.IR_ld), 16'd0);
        chk("rst_halted", 16'(bus.halted), 16'd0);
        rst = 1'b0;
        #1;
        chk("init_pc_clr", 16'(bus.PC_clr), 16'd1);
        step();
        chk("fetch_ir_ld", 16'(bus.IR_ld), 16'd1);
        chk("fetch_addr", 16'(bus.addr_MEM_sel), 16'd0);
        chk("fetch_pc_clr", 16'(bus.PC_clr), 16'd0);

        // ADD R1,R1,#2
        to_exec1(16'h1262);
        chk("add_b_sel", 16'(bus.B_sel), 16'd1);
        chk("add_sext", bus.sext_data, 16'h0002);
        chk("add_w_addr", 16'(bus.w_addr_RF), 16'd1);
        chk("add_w_en", 16'(bus.w_en_RF), 16'd1);
        chk("add_w_sel", 16'(bus.w_RF_sel), 16'd2);
        chk("add_nzp_ld", 16'({bus.N_ld, bus.Z_ld, bus.P_ld}), 16'd7);
        chk("add_r0", 16'(bus.r_addr_0_RF), 16'd1);
        chk("add_a_sel", 16'(bus.A_sel), 16'd1);
        step();
        chk("add_back_fetch", 16'(bus.IR_ld), 16'd1);

        // BRnp #-3 with only z set: not taken
        bus.z_flag = 1'b1;
        to_exec1(16'h0BFD);
        chk("br_z_not_taken", 16'(bus.PC_ld), 16'd0);
        step();
        // same branch with n set: taken via off9 adder
        bus.z_flag = 1'b0;
        bus.n_flag = 1'b1;
        to_exec1(16'h0BFD);
        chk("br_n_taken", 16'(bus.PC_ld), 16'd1);
        chk("br_add_sel", 16'(bus.PC_add_sel), 16'd1);
        chk("br_data_sel", 16'(bus.PC_data_sel), 16'd0);
        step();
        // nzp=000 never taken even with all flags set
        bus.z_flag = 1'b1;
        bus.p_flag = 1'b1;
        to_exec1(16'h01FD);
        chk("br_000_never", 16'(bus.PC_ld), 16'd0);
        step();

        // LDI R2, #2: five-cycle instruction
        to_exec1(16'hA402);
        chk("ldi_store_ld", 16'(bus.store_ld), 16'd1);
        chk("ldi_e1_addr", 16'(bus.addr_MEM_sel), 16'd1);
        chk("ldi_e1_w_en", 16'(bus.w_en_RF), 16'd0);
        step();
        chk("ldi_e2_addr", 16'(bus.addr_MEM_sel), 16'd2);
        chk("ldi_e2_w_sel", 16'(bus.w_RF_sel), 16'd1);
        chk("ldi_e2_w_en", 16'(bus.w_en_RF), 16'd1);
        chk("ldi_e2_w_addr", 16'(bus.w_addr_RF), 16'd2);
        step();
        chk("ldi_e3_nzp_sel", 16'(bus.NZP_sel), 16'd1);
        chk("ldi_e3_r0", 16'(bus.r_addr_0_RF), 16'd2);
        chk("ldi_e3_w_en", 16'(bus.w_en_RF), 16'd0);
        step();
        chk("ldi_back_fetch", 16'(bus.IR_ld), 16'd1);

        // JSR #-1: link write and PC load together
        to_exec1(16'h4FFF);
        chk("jsr_w_addr", 16'(bus.w_addr_RF), 16'd7);
        chk("jsr_w_sel", 16'(bus.w_RF_sel), 16'd0);
        chk("jsr_w_en", 16'(bus.w_en_RF), 16'd1);
        chk("jsr_pc_ld", 16'(bus.PC_ld), 16'd1);
        chk("jsr_add_sel", 16'(bus.PC_add_sel), 16'd0);
        chk("jsr_sext", bus.sext_data, 16'hFFFF);
        step();

        // JMP R7
        to_exec1(16'hC1C0);
        chk("jmp_pc_ld", 16'(bus.PC_ld), 16'd1);
        chk("jmp_data_sel", 16'(bus.PC_data_sel), 16'd1);
        chk("jmp_alu", 16'(bus.ALU_sel), 16'd2);
        chk("jmp_r0", 16'(bus.r_addr_0_RF), 16'd7);
        step();

        // LDR R5, R1, #-1: four-cycle instruction
        to_exec1(16'h6A7F);
        chk("ldr_sext", bus.sext_data, 16'hFFFF);
        chk("ldr_a_sel", 16'(bus.A_sel), 16'd1);
        chk("ldr_addr", 16'(bus.addr_MEM_sel), 16'd1);
        chk("ldr_w_addr", 16'(bus.w_addr_RF), 16'd5);
        step();
        chk("ldr_e3_nzp_sel", 16'(bus.NZP_sel), 16'd1);
        chk("ldr_e3_r0", 16'(bus.r_addr_0_RF), 16'd5);
        step();
        chk("ldr_back_fetch", 16'(bus.IR_ld), 16'd1);

        // STI R3, then reset during EXEC2
        to_exec1(16'hB603);
        chk("sti_store_ld", 16'(bus.store_ld), 16'd1);
        step();
        chk("sti_e2_w_mem", 16'(bus.w_en_MEM), 16'd1);
        chk("sti_e2_addr", 16'(bus.addr_MEM_sel), 16'd2);
        chk("sti_e2_r1", 16'(bus.r_addr_1_RF), 16'd3);
        chk("sti_e2_w_rf", 16'(bus.w_en_RF), 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("sti_rst_w_mem", 16'(bus.w_en_MEM), 16'd0);
        chk("sti_rst_pc_clr", 16'(bus.PC_clr), 16'd1);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_fetch", 16'(bus.IR_ld), 16'd1);

        // HALT
        to_exec1(16'hF025);
        chk("trap_not_halted", 16'(bus.halted), 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_halted", 16'(bus.halted), 16'd1);
            chk("halt_enables", 16'({bus.PC_inc, bus.IR_ld, bus.PC_ld, bus.w_en_RF, bus.w_en_MEM}),
                16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected %0d", 1, 0);
        $fatal(1);
    end
endmodule
